// File: rtl/gpu_pkg.sv
// Purpose: shared constants, receiver state encoding and length helper for the program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpu_pkg;

  localparam int FRAME_W     = 16;  // width of one program word
  localparam int FRAME_WORDS = 16;  // program length granule, in words
  localparam int HDR_WORDS   = 3;   // header + mask + mask copy
  localparam int LEN_W       = 6;   // width of the length field N in the header
  localparam int CORE_NUM    = 16;  // cores addressed by the mask
  localparam int CNT_W       = 10;  // payload index width, covers 0..1020

  typedef enum logic [2:0] {
    IDLE,
    MASK0,
    MASK1,
    LOAD,
    SKIP,
    EXEC
  } rx_state_t;

  // Index of the final payload word: (N+1)*16 - HDR_WORDS - 1 = N*16 + 12.
  function automatic logic [CNT_W-1:0] last_payload_idx(input logic [LEN_W-1:0] n);
    return {n, 4'd12};
  endfunction

endpackage

// File: rtl/core_frame_receiver.sv
// Purpose: snoops the scheduler broadcast bus and writes programs addressed to this core into its imem.
// Latency: each accepted payload word appears on the imem write port one cycle after it is sampled.
// Backpressure: none; the bus never stalls, gaps in frame_valid simply produce no writes.
module core_frame_receiver
  import gpu_pkg::*;
#(
  parameter int CORE_ID = 0,
  parameter int IMEM_AW = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_valid,
  input  logic               frame_being_sent,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               core_release,
  output logic               core_ready,
  output logic               core_reading,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [FRAME_W-1:0] imem_wdata,
  output logic               prog_done,
  output logic               hdr_error
);

  rx_state_t          state;
  rx_state_t          state_nxt;
  logic [CNT_W-1:0]   idx;       // payload index of the next word within the packet
  logic [CNT_W-1:0]   last_idx;  // payload index of the packet's final word
  logic [FRAME_W-1:0] mask_lat;
  logic               busy;      // core holds a program and has not released it yet

  logic hdr;
  logic in_pkt;
  logic final_slot;
  logic abort;
  logic hdr_take;
  logic mask_eq;
  logic mask_hit;
  logic accept;
  logic release_hit;

  // Decode of the current bus word against the packet position.
  always_comb begin
    hdr         = frame_valid && frame_being_sent;
    in_pkt      = (state == MASK0) || (state == MASK1) || (state == LOAD) || (state == SKIP);
    // The last word of a packet is data even if the strobe happens to be high.
    final_slot  = ((state == LOAD) || (state == SKIP)) && (idx == last_idx);
    abort       = hdr && in_pkt && !final_slot;
    hdr_take    = hdr && ((state == IDLE) || (state == EXEC) || abort);
    mask_eq     = (frame_data == mask_lat);
    mask_hit    = mask_lat[CORE_ID] || frame_data[CORE_ID];
    accept      = (state == MASK1) && frame_valid && !abort && mask_lat[CORE_ID] && mask_eq && !busy;
    // A loading core cannot be executing, so a release there is meaningless.
    release_hit = core_release && busy && (state != LOAD);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a new header always wins and restarts at MASK0.
  always_comb begin
    state_nxt = state;
    if (hdr_take) begin
      state_nxt = MASK0;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        MASK0: if (frame_valid) state_nxt = MASK1;
        MASK1: if (frame_valid) state_nxt = accept ? LOAD : SKIP;
        LOAD:  if (frame_valid && final_slot) state_nxt = EXEC;
        // A packet skipped while the core executes returns to EXEC so the release is still seen.
        SKIP:  if (frame_valid && final_slot) state_nxt = (busy && !release_hit) ? EXEC : IDLE;
        EXEC:  if (core_release) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Moore outputs derived from state and the busy flag.
  always_comb begin
    core_ready   = !busy;
    core_reading = (state == LOAD);
  end

  // Datapath: header/mask latches, payload counter, busy flag and registered imem port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx        <= '0;
      last_idx   <= '0;
      mask_lat   <= '0;
      busy       <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      prog_done  <= 1'b0;
      hdr_error  <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      prog_done <= 1'b0;
      hdr_error <= 1'b0;

      if (release_hit) begin
        busy <= 1'b0;
      end

      if (hdr_take) begin
        last_idx <= last_payload_idx(frame_data[LEN_W-1:0]);
        idx      <= '0;
        if (abort) begin
          hdr_error <= 1'b1;
          // An interrupted load leaves the core without a program, so it is idle again.
          if (state == LOAD) begin
            busy <= 1'b0;
          end
        end
      end else if (frame_valid) begin
        case (state)
          MASK0: mask_lat <= frame_data;
          MASK1: begin
            idx <= '0;
            if (accept) begin
              busy <= 1'b1;
            end
            // Corrupted mask, or a program aimed at a core that is still executing.
            if (mask_hit && (!mask_eq || busy)) begin
              hdr_error <= 1'b1;
            end
          end
          LOAD: begin
            imem_we    <= 1'b1;
            imem_addr  <= IMEM_AW'(idx);
            imem_wdata <= frame_data;
            prog_done  <= final_slot;
            idx        <= idx + CNT_W'(1);
          end
          SKIP: idx <= idx + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/core_frame_receiver.md
CORE_FRAME_RECEIVER -- requirements
Module: core_frame_receiver

Interface
REQ-001 SHALL have parameter CORE_ID, default 0: bit index of this core in the scheduler's 16-bit core mask.
REQ-002 SHALL have parameter IMEM_AW, default 10: local instruction-memory address width (1024 words).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 frame_valid  input  1  frame_data carries a program word this cycle.
REQ-006 frame_being_sent  input  1  start-of-program strobe; qualified by frame_valid, marks the header word.
REQ-007 frame_data  input  16  program word from the scheduler broadcast bus.
REQ-008 core_release  input  1  one-cycle pulse from the core: execution finished, core may accept a new program.
REQ-009 core_ready  output  1  core idle and able to accept a program.
REQ-010 core_reading  output  1  this core is absorbing a program addressed to it.
REQ-011 imem_we, imem_addr[IMEM_AW-1:0], imem_wdata[15:0]  output  instruction-memory write port.
REQ-012 prog_done  output  1  one-cycle pulse when the last payload word is written.
REQ-013 hdr_error  output  1  one-cycle pulse on a protocol violation.

Function
REQ-014 Program format SHALL be: word0 header, N = header[5:0], header[15:6] ignored; word1 mask; word2 mask copy; total length (N+1)*16 words; payload = (N+1)*16-3 words following word2.
REQ-015 States SHALL be IDLE, MASK0, MASK1, LOAD, SKIP, EXEC.
REQ-016 IDLE: on frame_valid & frame_being_sent, latch N -> MASK0; frame_valid without the strobe is ignored.
REQ-017 MASK0: on frame_valid, latch the mask -> MASK1.
REQ-018 MASK1: on frame_valid, target = mask[CORE_ID] & (word == latched mask) & core_ready; target -> LOAD, otherwise -> SKIP.
REQ-019 Mask mismatch in MASK1 with mask[CORE_ID] set in either word SHALL pulse hdr_error in the cycle after MASK1 samples the copy, then go to SKIP.
REQ-020 LOAD: each frame_valid word SHALL produce, one cycle later, imem_we=1, imem_wdata=word, imem_addr=payload index (0-based); gaps in frame_valid produce no writes.
REQ-021 The last payload word (index (N+1)*16-4) SHALL assert prog_done in the same cycle as its imem_we, then enter EXEC.
REQ-022 SKIP: SHALL count words to the program end with no writes, then return to IDLE; core_ready unchanged.
REQ-023 EXEC: core_ready=0; a core_release pulse -> IDLE. Packets arriving in EXEC are tracked through SKIP semantics with core_ready held 0; a header targeting this core in EXEC pulses hdr_error.
REQ-024 core_ready SHALL be 1 in IDLE and in SKIP entered from IDLE, and 0 from the MASK1 accept through EXEC.
REQ-025 core_reading SHALL be 1 exactly while in LOAD.
REQ-026 frame_valid & frame_being_sent outside IDLE, and outside the final word slot, SHALL abort the current packet: no further writes, hdr_error pulse, word treated as a new header (-> MASK0).
REQ-027 The word counter SHALL be 10 bits and SHALL cover N=63: 1024 total words, 1021 payload, last address 1020; no wrap.
REQ-028 core_release outside EXEC SHALL be ignored.

Reset
REQ-029 On reset=0 at a clock edge: state IDLE, counters 0, core_ready=1, core_reading=0, imem_we=0, imem_addr=0, imem_wdata=0, prog_done=0, hdr_error=0.
REQ-030 Reset mid-LOAD SHALL abandon the packet; after release, remaining words of that packet are ignored until the next frame_being_sent.

Structure
REQ-031 Package gpu_pkg SHALL hold FRAME_W=16, FRAME_WORDS=16, HDR_WORDS=3, LEN_W=6, CORE_NUM=16 and the receiver state enum.
REQ-032 SHALL be one flat module with no sub-module; the instruction memory is external.

Verification
REQ-033 CORE_ID=0, continuous stream 0x0003, 0x000f, 0x000f, 61 random words -> 61 writes at addr 0..60 with matching data, prog_done with the addr-60 write, core_ready=0 until core_release.
REQ-034 CORE_ID=4, same packet -> no imem_we, core_ready stays 1, IDLE after word 64; the next packet 0x0007, 0x00f0, 0x00f0 -> 125 writes, last addr 124.
REQ-035 Header 0x002f, masks 0x0f00/0x0f00, CORE_ID=8, frame_valid toggling every cycle -> 765 writes, addresses contiguous 0..764.
REQ-036 Masks 0x000f/0x000e, CORE_ID=0 -> hdr_error pulse, no writes, IDLE after 64 words.
REQ-037 frame_being_sent re-asserted at payload word 10 -> hdr_error, writes stop at addr 9, new packet loads from addr 0.
REQ-038 reset=0 for one cycle at payload word 20, then stream continues -> outputs take reset values, no further writes, core_ready=1.
